math_inverse_seq: RTL and testbench
===================================

// Module: math_inverse_seq
// PURPOSE
//  Sequential inverse of the square/cube/factorial operator unit. Given a
//  13-bit value and op select, finds largest 3-bit k with f(k) <= value
//  by an ascending one-candidate-per-cycle search, flags exact hit and
//  saturation. Start/done handshake. Sits beside the forward op unit so
//  its results can be checked or decoded.
// PARAMETERS
//  IN_W   3   root width; candidates k = 0 .. 2**IN_W-1
//  OUT_W  13  value width; must hold f(2**IN_W-1) for every op (7! = 5040)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only when busy=0
//  s      in   2      op: 00 zero, 01 square, 10 cube, 11 factorial
//  val    in   OUT_W  value to invert, unsigned
//  root   out  IN_W   result k
//  exact  out  1      1 when f(root) == latched val
//  sat    out  1      1 when latched val > f(2**IN_W-1)
//  busy   out  1      high from the edge after start is accepted until done
//  done   out  1      one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-search): state IDLE, k=0;
//    root=0 exact=0 sat=0 busy=0 done=0. Latched operands cleared.
//  - f(k): 00 -> 0; 01 -> k*k; 10 -> k*k*k; 11 -> k! with 0! defined as 0
//    (1!=1, 2!=2, 3!=6 ... 7!=5040). Unsigned, OUT_W bits, no truncation at
//    defaults. All ops except 00 are strictly increasing in k.
//  - FSM IDLE -> SEARCH -> IDLE. Edge E0 in IDLE with start=1: latch s,val;
//    k<=0; busy<=1; state<=SEARCH. start with busy=1 is ignored.
//  - SEARCH, edge E(k+1) evaluates candidate k. Termination, first match:
//    s==00           : root=0, exact=(val==0), sat=0
//    f(k)==val       : root=k, exact=1, sat=0
//    f(k)>val        : root=k-1, exact=0, sat=0 (k>=1 guaranteed, f(0)=0)
//    k==max, f(k)<val: root=max, exact=0, sat=1
//    else k<=k+1, stay in SEARCH.
//  - At terminating edge: root/exact/sat registered, done<=1 for exactly one
//    cycle, busy<=0, state<=IDLE. Latency start-edge to done-high =
//    k_term+1 edges (1..8 at defaults).
//  - root/exact/sat hold until the next completion; not changed by start.
//  - start may be high in the cycle done is high: accepted (back-to-back).
//  - k is IN_W bits; never increments past max (no wrap).
// STRUCTURE
//  - Package math_ops_pkg: OP_ZERO/OP_SQUARE/OP_CUBE/OP_FACT 2-bit codes,
//    IN_W/OUT_W default constants, FSM state encoding.
//  - Sub-module math_op_eval: combinational f(k,s) -> OUT_W, shared with
//    the forward unit's checker. Top keeps FSM, k counter, comparator,
//    output registers.
// TESTING
//  1. s=01 val=16 -> root=4 exact=1 sat=0; done high after edge E5.
//  2. s=10 val=100 -> f(5)=125>100: root=4 exact=0 sat=0; done after E6.
//  3. s=11 val=720 -> root=6 exact=1 after E7; s=11 val=0 -> root=0
//     exact=1 after E1.
//  4. s=10 val=8191 -> root=7 exact=0 sat=1; done after E8, busy 7 cycles.
//  5. s=00 val=5 -> root=0 exact=0 after E1; start pulsed while busy during
//     a s=01 val=49 run is ignored (one done, root=7 exact=1).
//  6. rst_n low mid-search (s=11 val=5040, at E3) -> all outputs 0 at once;
//     after release, s=01 val=9 -> root=3 exact=1 after E4.
//  Every case: done width exactly 1 cycle; compare against a model looping
//  f(k) over k=0..7 for all 4 ops and a random sample of val.

Source files
------------

// File: rtl/math_ops_pkg.sv
// rtl/math_ops_pkg.sv - shared op codes, default widths and FSM encoding for the math inverse unit
package math_ops_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W_DEF = 13;

  typedef enum logic [1:0] {
    OP_ZERO   = 2'b00,
    OP_SQUARE = 2'b01,
    OP_CUBE   = 2'b10,
    OP_FACT   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

endpackage

// File: rtl/math_op_eval.sv
// rtl/math_op_eval.sv - combinational f(k,s): zero, square, cube or factorial of k
module math_op_eval
  import math_ops_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  k,
  input  op_e              s,
  output logic [OUT_W-1:0] f
);

  logic [OUT_W-1:0] kx;
  logic [OUT_W-1:0] fact;

  always_comb begin
    kx   = OUT_W'(k);
    fact = '0;
    // 0! is deliberately 0 so every op gives f(0)=0
    if (k != '0) begin
      fact = OUT_W'(1);
      for (int i = 2; i < 2**IN_W; i++) begin
        if (i <= int'(k)) fact = fact * OUT_W'(i);
      end
    end
    case (s)
      OP_SQUARE: f = kx * kx;
      OP_CUBE:   f = kx * kx * kx;
      OP_FACT:   f = fact;
      default:   f = '0;
    endcase
  end

endmodule

// File: rtl/math_inverse_seq.sv
// rtl/math_inverse_seq.sv - ascending one-candidate-per-cycle inverse search over f(k)
module math_inverse_seq
  import math_ops_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       s,
  input  logic [OUT_W-1:0] val,
  output logic [IN_W-1:0]  root,
  output logic             exact,
  output logic             sat,
  output logic             busy,
  output logic             done
);

  localparam logic [IN_W-1:0] K_MAX = '1;

  state_e           state;
  logic [IN_W-1:0]  k;
  op_e              s_q;
  logic [OUT_W-1:0] val_q;
  logic [OUT_W-1:0] f_k;

  logic             hit;
  logic [IN_W-1:0]  res_root;
  logic             res_exact;
  logic             res_sat;

  math_op_eval #(.IN_W(IN_W), .OUT_W(OUT_W)) u_eval (
    .k (k),
    .s (s_q),
    .f (f_k)
  );

  // f is monotonic for non-zero ops, so the first candidate at or above val decides
  always_comb begin
    hit       = 1'b1;
    res_root  = k;
    res_exact = 1'b0;
    res_sat   = 1'b0;
    if (s_q == OP_ZERO) begin
      res_root  = '0;
      res_exact = (val_q == '0);
    end else if (f_k == val_q) begin
      res_exact = 1'b1;
    end else if (f_k > val_q) begin
      res_root = k - IN_W'(1);
    end else if (k == K_MAX) begin
      res_sat = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
      s_q   <= OP_ZERO;
      val_q <= '0;
      root  <= '0;
      exact <= 1'b0;
      sat   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            s_q   <= op_e'(s);
            val_q <= val;
            k     <= '0;
            busy  <= 1'b1;
            state <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit) begin
            root  <= res_root;
            exact <= res_exact;
            sat   <= res_sat;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            k <= k + IN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_math_inverse_seq.sv
// tb/tb_math_inverse_seq.sv - directed and model-checked bench for math_inverse_seq
module tb_math_inverse_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  s;
  logic [12:0] val;
  logic [2:0]  root;
  logic        exact;
  logic        sat;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int last_root = 0;

  int sq_t [8] = '{0, 1, 4, 9, 16, 25, 36, 49};
  int cu_t [8] = '{0, 1, 8, 27, 64, 125, 216, 343};
  int fa_t [8] = '{0, 1, 2, 6, 24, 120, 720, 5040};

  math_inverse_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .s     (s),
    .val   (val),
    .root  (root),
    .exact (exact),
    .sat   (sat),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int fval(input int op, input int k);
    case (op)
      1: return sq_t[k];
      2: return cu_t[k];
      3: return fa_t[k];
      default: return 0;
    endcase
  endfunction

  task automatic model(input int op, input int v, output int r, output int e, output int st, output int lat);
    int fk;
    r = 7; e = 0; st = 1; lat = 8;
    if (op == 0) begin
      r = 0; e = (v == 0) ? 1 : 0; st = 0; lat = 1;
    end else begin
      for (int kk = 0; kk < 8; kk++) begin
        fk = fval(op, kk);
        if (fk >= v) begin
          r = (fk == v) ? kk : kk - 1;
          e = (fk == v) ? 1 : 0;
          st = 0;
          lat = kk + 1;
          break;
        end
      end
    end
  endtask

  // Called #1 after a rising edge; that next edge is E0
  task automatic launch(input logic [1:0] op, input int v);
    start = 1'b1;
    s     = op;
    val   = 13'(v);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_width", {31'b0, done}, 0);
    check("busy_after_start", {31'b0, busy}, 1);
    check("root_hold", {29'b0, root}, last_root);
  endtask

  task automatic wait_done(input string tag, input int er, input int ee, input int es,
                           input int elat, input bit poke);
    int n = 0;
    int nbusy = 0;
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) begin
        start = 1'b1; s = 2'b00; val = 13'd5;
      end
      if (poke && n == 3) start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
    end
    check({tag, "_seen"}, {31'b0, seen}, 1);
    check({tag, "_latency"}, n, elat);
    check({tag, "_root"}, {29'b0, root}, er);
    check({tag, "_exact"}, {31'b0, exact}, ee);
    check({tag, "_sat"}, {31'b0, sat}, es);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 0);
    check({tag, "_busy_cycles"}, nbusy, elat - 1);
    last_root = er;
  endtask

  initial begin
    int r, e, st, lat, op, v;
    rst_n = 1'b0;
    start = 1'b0;
    s     = 2'b00;
    val   = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_root", {29'b0, root}, 0);
    check("rst_exact", {31'b0, exact}, 0);
    check("rst_sat", {31'b0, sat}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    launch(2'b01, 16);   wait_done("sq16",   4, 1, 0, 5, 0);
    launch(2'b10, 100);  wait_done("cu100",  4, 0, 0, 6, 0);
    launch(2'b11, 720);  wait_done("fa720",  6, 1, 0, 7, 0);
    launch(2'b11, 0);    wait_done("fa0",    0, 1, 0, 1, 0);
    launch(2'b10, 8191); wait_done("cu8191", 7, 0, 1, 8, 0);
    launch(2'b00, 5);    wait_done("zero5",  0, 0, 0, 1, 0);
    launch(2'b01, 49);   wait_done("sq49_ignored_start", 7, 1, 0, 8, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("single_done", {31'b0, done}, 0);
    end

    launch(2'b11, 5040);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_root", {29'b0, root}, 0);
    check("midrst_exact", {31'b0, exact}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_root = 0;
    @(posedge clk); #1;
    launch(2'b01, 9);    wait_done("sq9",    3, 1, 0, 4, 0);

    launch(2'b11, 5041); wait_done("fa5041", 7, 0, 1, 8, 0);
    launch(2'b11, 1);    wait_done("fa1",    1, 1, 0, 2, 0);

    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 3);
      v  = (op == 1) ? $urandom_range(0, 60) :
           (op == 2) ? $urandom_range(0, 400) : $urandom_range(0, 6000);
      model(op, v, r, e, st, lat);
      launch(2'(op), v);
      wait_done($sformatf("rnd%0d", i), r, e, st, lat, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
